// File: rtl/branch_wb_collector_pkg.sv
// rtl/branch_wb_collector_pkg.sv - shared branch writeback types and ROB age compare
package branch_wb_collector_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = 6;

  typedef struct packed {
    logic                 flipped;
    logic [ROB_IDX_W-1:0] idx;
  } robIdx_t;

  typedef struct packed {
    robIdx_t         rob_idx;
    logic            has_mispred;
    logic            taken;
    logic [XLEN-1:0] branch_npc;
  } branchwbInfo_t;

  typedef enum logic {
    HOLD_EMPTY,
    HOLD_VALID
  } hold_state_t;

  // Matching flip bits compare directly; differing flip bits mean the ROB wrapped.
  function automatic logic rob_older(robIdx_t a, robIdx_t b);
    return (a.flipped == b.flipped) ? (a.idx < b.idx) : (a.idx > b.idx);
  endfunction

endpackage

// File: rtl/branch_wb_collector_if.sv
// rtl/branch_wb_collector_if.sv - BRU writeback in, FTQ/ROB/frontend out
interface branch_wb_collector_if
  import branch_wb_collector_pkg::*;
#(
  parameter int BRU_NUM   = 2,
  parameter int CNT_WIDTH = 32
) ();

  logic                          i_squash_vld;
  logic          [BRU_NUM-1:0]   i_wb_vld;
  branchwbInfo_t [BRU_NUM-1:0]   i_wb_info;
  logic          [BRU_NUM-1:0]   o_ftq_wb_vld;
  branchwbInfo_t [BRU_NUM-1:0]   o_ftq_wb_info;
  logic                          o_mispred_vld;
  branchwbInfo_t                 o_mispred_info;
  logic                          o_redirect_vld;
  logic          [XLEN-1:0]      o_redirect_pc;
  logic          [CNT_WIDTH-1:0] o_mispred_cnt;

  modport master (
    output i_squash_vld, i_wb_vld, i_wb_info,
    input  o_ftq_wb_vld, o_ftq_wb_info, o_mispred_vld, o_mispred_info,
           o_redirect_vld, o_redirect_pc, o_mispred_cnt
  );

  modport slave (
    input  i_squash_vld, i_wb_vld, i_wb_info,
    output o_ftq_wb_vld, o_ftq_wb_info, o_mispred_vld, o_mispred_info,
           o_redirect_vld, o_redirect_pc, o_mispred_cnt
  );

endinterface

// File: rtl/branch_oldest_sel.sv
// rtl/branch_oldest_sel.sv - BRU_NUM-way oldest mispredict reduction
module branch_oldest_sel
  import branch_wb_collector_pkg::*;
#(
  parameter int BRU_NUM = 2,
  parameter int IW      = (BRU_NUM > 1) ? $clog2(BRU_NUM) : 1
) (
  input  logic    [BRU_NUM-1:0] req,
  input  robIdx_t [BRU_NUM-1:0] rob,
  output logic                  cand_vld,
  output logic    [IW-1:0]      cand_idx
);

  robIdx_t best;

  // Strictly-older replacement keeps the lower port on an exact tie.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    best     = '0;
    for (int i = 0; i < BRU_NUM; i++) begin
      if (req[i] && (!cand_vld || rob_older(rob[i], best))) begin
        cand_vld = 1'b1;
        cand_idx = IW'(i);
        best     = rob[i];
      end
    end
  end

endmodule

// File: rtl/branch_wb_collector.sv
// rtl/branch_wb_collector.sv - forwards BRU writebacks to FTQ, holds oldest mispredict for ROB
module branch_wb_collector
  import branch_wb_collector_pkg::*;
#(
  parameter int BRU_NUM   = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_wb_collector_if.slave  bus
);

  localparam int IW = (BRU_NUM > 1) ? $clog2(BRU_NUM) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic          [BRU_NUM-1:0]   req;
  robIdx_t       [BRU_NUM-1:0]   rob;
  logic                          cand_vld;
  logic          [IW-1:0]        cand_idx;
  branchwbInfo_t                 cand_info;
  logic                          capture;

  hold_state_t                   state_q, state_d;
  branchwbInfo_t                 held_q;
  logic          [BRU_NUM-1:0]   ftq_vld_q;
  branchwbInfo_t [BRU_NUM-1:0]   ftq_info_q;
  logic                          redirect_vld_q;
  logic          [XLEN-1:0]      redirect_pc_q;
  logic          [CNT_WIDTH-1:0] cnt_q;

  always_comb begin
    req = '0;
    rob = '0;
    for (int i = 0; i < BRU_NUM; i++) begin
      req[i] = bus.i_wb_vld[i] & bus.i_wb_info[i].has_mispred;
      rob[i] = bus.i_wb_info[i].rob_idx;
    end
  end

  branch_oldest_sel #(.BRU_NUM(BRU_NUM), .IW(IW)) u_sel (
    .req      (req),
    .rob      (rob),
    .cand_vld (cand_vld),
    .cand_idx (cand_idx)
  );

  assign cand_info = bus.i_wb_info[cand_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HOLD_EMPTY;
    else     state_q <= state_d;
  end

  // Squash wins over any same-cycle writeback.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (bus.i_squash_vld) begin
      state_d = HOLD_EMPTY;
    end else if (cand_vld) begin
      case (state_q)
        HOLD_EMPTY: capture = 1'b1;
        HOLD_VALID: capture = rob_older(cand_info.rob_idx, held_q.rob_idx);
        default:    capture = 1'b0;
      endcase
      if (capture) state_d = HOLD_VALID;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q         <= '0;
      ftq_vld_q      <= '0;
      ftq_info_q     <= '0;
      redirect_vld_q <= 1'b0;
      redirect_pc_q  <= '0;
      cnt_q          <= '0;
    end else begin
      ftq_vld_q      <= bus.i_wb_vld & {BRU_NUM{~bus.i_squash_vld}};
      ftq_info_q     <= bus.i_wb_info;
      redirect_vld_q <= capture;
      if (capture) begin
        held_q        <= cand_info;
        redirect_pc_q <= cand_info.branch_npc;
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.o_ftq_wb_vld   = ftq_vld_q;
  assign bus.o_ftq_wb_info  = ftq_info_q;
  assign bus.o_mispred_vld  = (state_q == HOLD_VALID);
  assign bus.o_mispred_info = held_q;
  assign bus.o_redirect_vld = redirect_vld_q;
  assign bus.o_redirect_pc  = redirect_pc_q;
  assign bus.o_mispred_cnt  = cnt_q;

endmodule

// File: tb/tb_branch_wb_collector.sv
// tb/tb_branch_wb_collector.sv - scoreboard bench for branch_wb_collector
module tb_branch_wb_collector;
  import branch_wb_collector_pkg::*;

  typedef struct packed {
    logic [1:0]          ftq_vld;
    branchwbInfo_t [1:0] ftq_info;
    logic                mis_vld;
    robIdx_t             held;
    logic                redir;
    logic [31:0]         pc;
    logic [31:0]         cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  exp_t       sb[$];
  logic [2:0] sb2[$];

  logic          m_vld;
  branchwbInfo_t m_held;
  logic [31:0]   m_pc;
  logic [31:0]   m_cnt;

  branch_wb_collector_if #(.BRU_NUM(2), .CNT_WIDTH(32)) bus ();
  branch_wb_collector_if #(.BRU_NUM(2), .CNT_WIDTH(3))  bus2 ();

  branch_wb_collector #(.BRU_NUM(2), .CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  branch_wb_collector #(.BRU_NUM(2), .CNT_WIDTH(3)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic tb_older(robIdx_t a, robIdx_t b);
    if (a.flipped == b.flipped) return a.idx < b.idx;
    return a.idx > b.idx;
  endfunction

  function automatic branchwbInfo_t mk(input logic f, input logic [5:0] idx,
                                       input logic mis, input logic [31:0] npc);
    branchwbInfo_t r;
    r = '0;
    r.rob_idx.flipped = f;
    r.rob_idx.idx     = idx;
    r.has_mispred     = mis;
    r.branch_npc      = npc;
    return r;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.ftq_vld  = bus.o_ftq_wb_vld;
    o.ftq_info = bus.o_ftq_wb_info;
    o.mis_vld  = bus.o_mispred_vld;
    o.held     = bus.o_mispred_vld ? bus.o_mispred_info.rob_idx : '0;
    o.redir    = bus.o_redirect_vld;
    o.pc       = bus.o_redirect_pc;
    o.cnt      = bus.o_mispred_cnt;
    return o;
  endfunction

  task automatic model_reset();
    m_vld  = 1'b0;
    m_held = '0;
    m_pc   = '0;
    m_cnt  = '0;
  endtask

  // Drive one cycle of stimulus, push the model's prediction, advance past the edge.
  task automatic apply(input logic sq, input logic [1:0] v,
                       input branchwbInfo_t i0, input branchwbInfo_t i1);
    exp_t          e;
    branchwbInfo_t c;
    logic          r0, r1, cv, cap;
    bus.i_squash_vld = sq;
    bus.i_wb_vld     = v;
    bus.i_wb_info[0] = i0;
    bus.i_wb_info[1] = i1;
    r0 = v[0] & i0.has_mispred;
    r1 = v[1] & i1.has_mispred;
    cv = r0 | r1;
    if (r1 && (!r0 || tb_older(i1.rob_idx, i0.rob_idx))) c = i1;
    else if (r0) c = i0;
    else c = '0;
    cap = !sq && cv && (!m_vld || tb_older(c.rob_idx, m_held.rob_idx));
    if (sq) begin
      m_vld = 1'b0;
    end else if (cap) begin
      m_vld  = 1'b1;
      m_held = c;
      m_pc   = c.branch_npc;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    e.ftq_vld  = sq ? 2'b00 : v;
    e.ftq_info = {i1, i0};
    e.mis_vld  = m_vld;
    e.held     = m_vld ? m_held.rob_idx : '0;
    e.redir    = cap;
    e.pc       = m_pc;
    e.cnt      = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 2'b00, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_squash_vld  = 1'b0;
    bus.i_wb_vld      = '0;
    bus.i_wb_info     = '0;
    bus2.i_squash_vld = 1'b0;
    bus2.i_wb_vld     = '0;
    bus2.i_wb_info    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (bus.o_ftq_wb_vld !== 2'b00) begin errors++; $display("FAIL reset_ftq_vld got=%b exp=00", bus.o_ftq_wb_vld); end
    checks++; if (bus.o_ftq_wb_info !== '0) begin errors++; $display("FAIL reset_ftq_info got=%h exp=0", bus.o_ftq_wb_info); end
    checks++; if (bus.o_mispred_vld !== 1'b0) begin errors++; $display("FAIL reset_mispred_vld got=%b exp=0", bus.o_mispred_vld); end
    checks++; if (bus.o_mispred_info !== '0) begin errors++; $display("FAIL reset_mispred_info got=%h exp=0", bus.o_mispred_info); end
    checks++; if (bus.o_redirect_vld !== 1'b0) begin errors++; $display("FAIL reset_redirect_vld got=%b exp=0", bus.o_redirect_vld); end
    checks++; if (bus.o_redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc got=%h exp=0", bus.o_redirect_pc); end
    checks++; if (bus.o_mispred_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.o_mispred_cnt); end
    checks++; if (bus2.o_mispred_cnt !== 3'h0) begin errors++; $display("FAIL reset_cnt_small got=%0d exp=0", bus2.o_mispred_cnt); end
  endtask

  task automatic test_no_mispred();
    exp_t e, o;
    apply(1'b0, 2'b01, mk(1'b0, 6'd5, 1'b0, 32'h0000_0100), '0);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL no_mispred got=%h exp=%h", o, e); end
    checks++; if (bus.o_ftq_wb_vld !== 2'b01 || bus.o_mispred_vld !== 1'b0 || bus.o_mispred_cnt !== 32'd0) begin
      errors++; $display("FAIL no_mispred_const ftq=%b mis=%b cnt=%0d exp ftq=01 mis=0 cnt=0",
                         bus.o_ftq_wb_vld, bus.o_mispred_vld, bus.o_mispred_cnt);
    end
  endtask

  task automatic test_capture();
    exp_t e, o;
    apply(1'b0, 2'b01, mk(1'b0, 6'd10, 1'b1, 32'h8000_0040), '0);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL capture got=%h exp=%h", o, e); end
    checks++; if (bus.o_redirect_vld !== 1'b1 || bus.o_redirect_pc !== 32'h8000_0040 || bus.o_mispred_cnt !== 32'd1) begin
      errors++; $display("FAIL capture_const redir=%b pc=%h cnt=%0d exp redir=1 pc=80000040 cnt=1",
                         bus.o_redirect_vld, bus.o_redirect_pc, bus.o_mispred_cnt);
    end
    idle();
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL capture_pulse_drop got=%h exp=%h", o, e); end
    checks++; if (bus.o_redirect_vld !== 1'b0 || bus.o_redirect_pc !== 32'h8000_0040) begin
      errors++; $display("FAIL pulse_drop_const redir=%b pc=%h exp redir=0 pc=80000040", bus.o_redirect_vld, bus.o_redirect_pc);
    end
  endtask

  task automatic test_hold_replace();
    exp_t e, o;
    logic [5:0] idx_tab [3] = '{6'd12, 6'd0, 6'd7};
    logic [1:0] vld_tab [3] = '{2'b01, 2'b00, 2'b01};
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, vld_tab[k], mk(1'b0, idx_tab[k], 1'b1, 32'h8000_1000 + 32'(k * 4)), '0);
      e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL hold_replace step=%0d got=%h exp=%h", k, o, e); end
    end
    checks++; if (bus.o_mispred_info.rob_idx.idx !== 6'd7 || bus.o_mispred_cnt !== 32'd2) begin
      errors++; $display("FAIL replace_const idx=%0d cnt=%0d exp idx=7 cnt=2", bus.o_mispred_info.rob_idx.idx, bus.o_mispred_cnt);
    end
  endtask

  task automatic test_dual_port();
    exp_t e, o;
    branchwbInfo_t a0 [6];
    branchwbInfo_t a1 [6];
    logic          sq [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    a0 = '{'0, mk(1'b0, 6'd20, 1'b1, 32'hA000_0000), '0, mk(1'b0, 6'd33, 1'b1, 32'hB000_0000),
           '0, mk(1'b1, 6'd2, 1'b1, 32'hC000_0000)};
    a1 = '{'0, mk(1'b0, 6'd15, 1'b1, 32'hA000_0004), '0, mk(1'b0, 6'd33, 1'b1, 32'hB000_0004),
           '0, '0};
    for (int k = 0; k < 6; k++) begin
      apply(sq[k], sq[k] ? 2'b00 : 2'b11, a0[k], a1[k]);
      e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL dual_port step=%0d got=%h exp=%h", k, o, e); end
      if (k == 1) begin
        checks++; if (bus.o_mispred_info.rob_idx !== 7'd15 || bus.o_redirect_pc !== 32'hA000_0004) begin
          errors++; $display("FAIL dual_oldest rob=%h pc=%h exp rob=0f pc=a0000004", bus.o_mispred_info.rob_idx, bus.o_redirect_pc);
        end
      end
      if (k == 3) begin
        checks++; if (bus.o_redirect_pc !== 32'hB000_0000) begin
          errors++; $display("FAIL tie_lower_port pc=%h exp=b0000000", bus.o_redirect_pc);
        end
      end
    end
    apply(1'b0, 2'b10, '0, mk(1'b0, 6'd60, 1'b1, 32'hD000_0000));
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL flip_wrap got=%h exp=%h", o, e); end
    checks++; if (bus.o_mispred_info.rob_idx !== {1'b0, 6'd60} || bus.o_redirect_vld !== 1'b1) begin
      errors++; $display("FAIL flip_wrap_const rob=%h redir=%b exp rob=3c redir=1", bus.o_mispred_info.rob_idx, bus.o_redirect_vld);
    end
  endtask

  task automatic test_squash();
    exp_t e, o;
    logic [31:0] cnt_before;
    apply(1'b0, 2'b01, mk(1'b0, 6'd40, 1'b1, 32'h8000_2000), '0);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL squash_setup got=%h exp=%h", o, e); end
    cnt_before = bus.o_mispred_cnt;
    apply(1'b1, 2'b10, '0, mk(1'b0, 6'd3, 1'b1, 32'h8000_3000));
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL squash got=%h exp=%h", o, e); end
    checks++; if (bus.o_mispred_vld !== 1'b0 || bus.o_ftq_wb_vld !== 2'b00 || bus.o_redirect_vld !== 1'b0 ||
                  bus.o_mispred_cnt !== cnt_before) begin
      errors++; $display("FAIL squash_const mis=%b ftq=%b redir=%b cnt=%0d exp mis=0 ftq=00 redir=0 cnt=%0d",
                         bus.o_mispred_vld, bus.o_ftq_wb_vld, bus.o_redirect_vld, bus.o_mispred_cnt, cnt_before);
    end
    idle();
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL squash_after got=%h exp=%h", o, e); end
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 2'b01, mk(1'b0, 6'(30 - k), 1'b1, 32'h9000_0000 + 32'(k * 4)), '0);
      e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back step=%0d got=%h exp=%h", k, o, e); end
      checks++; if (bus.o_redirect_vld !== 1'b1) begin
        errors++; $display("FAIL back_to_back_pulse step=%0d got=%b exp=1", k, bus.o_redirect_vld);
      end
    end
  endtask

  task automatic test_random();
    exp_t e, o;
    branchwbInfo_t r0, r1;
    logic          sq;
    for (int k = 0; k < 300; k++) begin
      r0 = mk(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), $urandom);
      r1 = mk(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), $urandom);
      sq = ($urandom_range(0, 7) == 0);
      apply(sq, 2'($urandom_range(0, 3)), r0, r1);
      e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL random step=%0d got=%h exp=%h", k, o, e); end
    end
  endtask

  task automatic test_saturate();
    logic [2:0] ex;
    for (int k = 1; k <= 10; k++) begin
      bus2.i_squash_vld = 1'b0;
      bus2.i_wb_vld     = 2'b01;
      bus2.i_wb_info[0] = mk(1'b0, 6'(50 - k), 1'b1, 32'h7000_0000 + 32'(k));
      bus2.i_wb_info[1] = '0;
      sb2.push_back(3'((k > 7) ? 7 : k));
      @(posedge clk);
      #1;
      ex = sb2.pop_front();
      checks++;
      if (bus2.o_mispred_cnt !== ex) begin
        errors++; $display("FAIL saturate step=%0d got=%0d exp=%0d", k, bus2.o_mispred_cnt, ex);
      end
    end
    bus2.i_wb_vld = 2'b00;
  endtask

  task automatic test_async_reset();
    exp_t e, o;
    apply(1'b0, 2'b01, mk(1'b0, 6'd1, 1'b1, 32'h8000_4000), '0);
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL async_setup got=%h exp=%h", o, e); end
    bus.i_wb_vld = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.o_mispred_vld !== 1'b0 || bus.o_redirect_vld !== 1'b0 || bus.o_redirect_pc !== 32'h0 ||
                  bus.o_mispred_cnt !== 32'h0 || bus.o_ftq_wb_vld !== 2'b00 || bus.o_mispred_info !== '0) begin
      errors++; $display("FAIL async_reset mis=%b redir=%b pc=%h cnt=%0d ftq=%b exp all zero",
                         bus.o_mispred_vld, bus.o_redirect_vld, bus.o_redirect_pc, bus.o_mispred_cnt, bus.o_ftq_wb_vld);
    end
    checks++; if (bus2.o_mispred_cnt !== 3'h0) begin
      errors++; $display("FAIL async_reset_small cnt=%0d exp=0", bus2.o_mispred_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    apply(1'b0, 2'b10, '0, mk(1'b1, 6'd8, 1'b1, 32'h8000_5000));
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL first_after_reset got=%h exp=%h", o, e); end
    checks++; if (bus.o_mispred_cnt !== 32'd1 || bus.o_redirect_pc !== 32'h8000_5000) begin
      errors++; $display("FAIL first_after_reset_const cnt=%0d pc=%h exp cnt=1 pc=80005000", bus.o_mispred_cnt, bus.o_redirect_pc);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_no_mispred();
    test_capture();
    test_hold_replace();
    test_dual_port();
    test_squash();
    test_back_to_back();
    test_random();
    test_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
